// File: rtl/bm_mem.sv
// Bitmatrix column memory: assembles host write beats into full columns, tracks
// per-column valid flags, and serves one-cycle-latency column reads.
module bm_mem #(
   parameter int W             = 8,
   parameter int K_MAX         = 4,
   parameter int M_MAX         = 4,
   parameter int BM_COL_W      = K_MAX * W * W,
   parameter int BM_MEM_ADDR_W = $clog2(M_MAX),
   parameter int HOST_DATA_W   = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     host_bm_clr,
   input  logic                     host_bm_wr_en,
   input  logic [BM_MEM_ADDR_W-1:0] host_bm_wr_addr,
   input  logic [HOST_DATA_W-1:0]   host_bm_wr_data,
   output logic                     bm_mem_wr_busy,
   output logic [M_MAX-1:0]         bm_mem_col_valid,
   input  logic                     bm_cntl_bm_mem_rd_rq,
   input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
   output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
   output logic                     bm_mem_bm_cntl_rd_data_val,
   output logic                     bm_mem_rd_err
);

   localparam int BEATS = BM_COL_W / HOST_DATA_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [BM_MEM_ADDR_W-1:0] col_addr_q, col_addr_d;
   logic [BM_MEM_ADDR_W-1:0] commit_addr;
   logic [BM_COL_W-1:0]      asm_q, asm_d;
   logic [BM_COL_W-1:0]      commit_data;
   logic [M_MAX-1:0]         col_valid_q, col_valid_d;
   logic [BM_COL_W-1:0]      mem_q [M_MAX];
   logic                     beat_fire;
   logic                     last_beat;
   logic                     commit_ok;
   logic                     rd_hit;
   logic [BM_COL_W-1:0]      rd_data_q, rd_data_d;
   logic                     rd_val_q, rd_val_d;
   logic                     rd_err_q, rd_err_d;

   // Clear takes priority over any beat presented in the same cycle.
   always_comb begin
      beat_fire   = host_bm_wr_en && !host_bm_clr;
      last_beat   = beat_fire && (beat_cnt_q == LAST_BEAT);
      commit_addr = (beat_cnt_q == '0) ? host_bm_wr_addr : col_addr_q;
      commit_ok   = last_beat && (int'(commit_addr) < M_MAX);
      commit_data = asm_q;
      commit_data[(BEATS-1)*HOST_DATA_W +: HOST_DATA_W] = host_bm_wr_data;
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      col_addr_d = col_addr_q;
      asm_d      = asm_q;
      if (host_bm_clr) begin
         beat_cnt_d = '0;
      end else if (host_bm_wr_en) begin
         beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
         asm_d[beat_cnt_q*HOST_DATA_W +: HOST_DATA_W] = host_bm_wr_data;
         if (beat_cnt_q == '0) begin
            col_addr_d = host_bm_wr_addr;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < M_MAX; gi++) begin : g_valid
         assign col_valid_d[gi] = host_bm_clr ? 1'b0 :
            ((commit_ok && commit_addr == BM_MEM_ADDR_W'(gi)) ? 1'b1 : col_valid_q[gi]);
      end
   endgenerate

   // Reads see pre-update array and flags, giving read-before-write on collisions.
   always_comb begin
      rd_hit    = (int'(bm_cntl_bm_mem_rd_addr) < M_MAX) && col_valid_q[bm_cntl_bm_mem_rd_addr];
      rd_data_d = rd_data_q;
      rd_val_d  = bm_cntl_bm_mem_rd_rq;
      rd_err_d  = bm_cntl_bm_mem_rd_rq && !rd_hit;
      if (bm_cntl_bm_mem_rd_rq) begin
         rd_data_d = rd_hit ? mem_q[bm_cntl_bm_mem_rd_addr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (commit_ok) begin
         mem_q[commit_addr] <= commit_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt_q  <= '0;
         col_addr_q  <= '0;
         asm_q       <= '0;
         col_valid_q <= '0;
         rd_data_q   <= '0;
         rd_val_q    <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         col_addr_q  <= col_addr_d;
         asm_q       <= asm_d;
         col_valid_q <= col_valid_d;
         rd_data_q   <= rd_data_d;
         rd_val_q    <= rd_val_d;
         rd_err_q    <= rd_err_d;
      end
   end

   assign bm_mem_wr_busy             = (beat_cnt_q != '0);
   assign bm_mem_col_valid           = col_valid_q;
   assign bm_mem_bm_cntl_rd_data     = rd_data_q;
   assign bm_mem_bm_cntl_rd_data_val = rd_val_q;
   assign bm_mem_rd_err              = rd_err_q;

endmodule

// File: tb/tb_bm_mem.sv
// Scoreboard bench for bm_mem: read requests push expected responses, a negedge
// monitor pops them on each val pulse; status outputs are checked directly.
module tb_bm_mem;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         host_bm_clr = 1'b0;
   logic         host_bm_wr_en = 1'b0;
   logic [1:0]   host_bm_wr_addr = '0;
   logic [31:0]  host_bm_wr_data = '0;
   logic         bm_mem_wr_busy;
   logic [3:0]   bm_mem_col_valid;
   logic         rd_rq = 1'b0;
   logic [1:0]   rd_addr = '0;
   logic [255:0] rd_data;
   logic         rd_val;
   logic         rd_err;

   typedef struct {
      logic [255:0] data;
      logic         err;
      int           due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   bm_mem dut (
      .clk                        (clk),
      .rstn                       (rstn),
      .host_bm_clr                (host_bm_clr),
      .host_bm_wr_en              (host_bm_wr_en),
      .host_bm_wr_addr            (host_bm_wr_addr),
      .host_bm_wr_data            (host_bm_wr_data),
      .bm_mem_wr_busy             (bm_mem_wr_busy),
      .bm_mem_col_valid           (bm_mem_col_valid),
      .bm_cntl_bm_mem_rd_rq       (rd_rq),
      .bm_cntl_bm_mem_rd_addr     (rd_addr),
      .bm_mem_bm_cntl_rd_data     (rd_data),
      .bm_mem_bm_cntl_rd_data_val (rd_val),
      .bm_mem_rd_err              (rd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] pat(input int seed);
      logic [255:0] p;
      for (int n = 0; n < 8; n++) p[32*n +: 32] = 32'(seed * 65536 + n);
      return p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rstn && rd_val) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: val pulse at cycle %0d with no request pending", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rd_data !== e.data || rd_err !== e.err || cyc != e.due) begin
               errors++;
               $display("FAIL rd_resp: got data=%h err=%b cyc=%0d expected data=%h err=%b cyc=%0d",
                        rd_data, rd_err, cyc, e.data, e.err, e.due);
            end else begin
               $display("ok   rd_resp: data=%h err=%b", rd_data, rd_err);
            end
         end
      end else if (rstn && q.size() != 0 && q[0].due <= cyc) begin
         checks++;
         errors++;
         $display("FAIL rd_missing: no val pulse at cycle %0d, expected err=%b", cyc, q[0].err);
         void'(q.pop_front());
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] addr, input logic [31:0] d);
      host_bm_wr_en   = 1'b1;
      host_bm_wr_addr = addr;
      host_bm_wr_data = d;
      tick();
      host_bm_wr_en   = 1'b0;
   endtask

   task automatic write_col(input logic [1:0] addr, input int seed);
      logic [255:0] p;
      p = pat(seed);
      for (int n = 0; n < 8; n++) beat(addr, p[32*n +: 32]);
   endtask

   task automatic issue_rd(input logic [1:0] addr, input logic [255:0] d, input logic err);
      exp_t e;
      rd_rq   = 1'b1;
      rd_addr = addr;
      e.data  = d;
      e.err   = err;
      e.due   = cyc + 1;
      q.push_back(e);
   endtask

   task automatic rd(input logic [1:0] addr, input logic [255:0] d, input logic err);
      issue_rd(addr, d, err);
      tick();
      rd_rq = 1'b0;
   endtask

   initial begin
      logic [255:0] pa;
      logic [255:0] pb;
      pa = pat(32'h30);
      pb = pat(32'h4B);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bm_mem_wr_busy), 0);
      chk("rst_valid", 32'(bm_mem_col_valid), 0);
      chk("rst_rdval", 32'(rd_val), 0);
      chk("rst_rderr", 32'(rd_err), 0);
      chk("rst_rddata_lo", rd_data[31:0], 0);
      rstn = 1'b1;
      tick();

      rd(2'd2, '0, 1'b1);
      tick();

      // Single column write, beat n = n
      beat(2'd1, 32'd0);
      chk("busy_after_beat0", 32'(bm_mem_wr_busy), 1);
      for (int n = 1; n < 8; n++) beat(2'd1, 32'(n));
      chk("busy_after_beat7", 32'(bm_mem_wr_busy), 0);
      chk("valid_col1", 32'(bm_mem_col_valid), 32'h2);
      rd(2'd1, pat(0), 1'b0);

      // Four columns, back-to-back reads
      write_col(2'd0, 32'h30);
      write_col(2'd1, 32'h31);
      write_col(2'd2, 32'h32);
      write_col(2'd3, 32'h33);
      chk("valid_all", 32'(bm_mem_col_valid), 32'hF);
      issue_rd(2'd3, pat(32'h33), 1'b0); tick();
      issue_rd(2'd0, pat(32'h30), 1'b0); tick();
      issue_rd(2'd2, pat(32'h32), 1'b0); tick();
      issue_rd(2'd1, pat(32'h31), 1'b0); tick();
      rd_rq = 1'b0;
      tick();

      // Read/commit collision on col 0
      for (int n = 0; n < 7; n++) beat(2'd0, pb[32*n +: 32]);
      host_bm_wr_en   = 1'b1;
      host_bm_wr_data = pb[255:224];
      issue_rd(2'd0, pa, 1'b0);
      tick();
      host_bm_wr_en = 1'b0;
      rd(2'd0, pb, 1'b0);

      // Partial column then clear, then full column to col 2
      for (int n = 0; n < 4; n++) beat(2'd3, 32'hDEAD_0000 + 32'(n));
      chk("busy_partial", 32'(bm_mem_wr_busy), 1);
      host_bm_clr = 1'b1;
      tick();
      host_bm_clr = 1'b0;
      chk("busy_after_clr", 32'(bm_mem_wr_busy), 0);
      chk("valid_after_clr", 32'(bm_mem_col_valid), 0);
      write_col(2'd2, 32'h52);
      chk("valid_col2_only", 32'(bm_mem_col_valid), 32'h4);
      rd(2'd3, '0, 1'b1);
      rd(2'd2, pat(32'h52), 1'b0);

      // Read coinciding with clear sees pre-clear flags
      host_bm_clr = 1'b1;
      issue_rd(2'd2, pat(32'h52), 1'b0);
      tick();
      host_bm_clr = 1'b0;
      rd(2'd2, '0, 1'b1);

      // Clear together with beat 0 drops the beat
      host_bm_clr     = 1'b1;
      host_bm_wr_en   = 1'b1;
      host_bm_wr_addr = 2'd1;
      host_bm_wr_data = 32'h1234_5678;
      tick();
      host_bm_clr   = 1'b0;
      host_bm_wr_en = 1'b0;
      chk("clr_beat_busy", 32'(bm_mem_wr_busy), 0);
      chk("clr_beat_valid", 32'(bm_mem_col_valid), 0);

      // Reset mid-column discards the partial column
      for (int n = 0; n < 3; n++) beat(2'd1, 32'(n));
      chk("busy_before_rst", 32'(bm_mem_wr_busy), 1);
      rstn = 1'b0;
      #1;
      chk("busy_in_rst", 32'(bm_mem_wr_busy), 0);
      tick();
      rstn = 1'b1;
      write_col(2'd1, 32'h61);
      chk("valid_after_rst", 32'(bm_mem_col_valid), 32'h2);
      rd(2'd1, pat(32'h61), 1'b0);

      repeat (3) tick();
      chk("sb_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bm_mem.md
# bm_mem

Bitmatrix column memory for the erasure-coding accelerator. It sits directly upstream of the bitmatrix controller and serves its column read requests with fixed one-cycle latency. It is loaded from the host/control-register side over a narrow write port that assembles full bitmatrix columns from multiple beats. It also tracks which columns hold valid data.

## Interface
- W, 8, Galois-field word width (bits)
- K_MAX, 4, maximum data-chunk count
- M_MAX, 4, number of stored columns (maximum parity-chunk count)
- BM_COL_W, K_MAX*W*W (256), bits per bitmatrix column
- BM_MEM_ADDR_W, $clog2(M_MAX) (2), column address width
- HOST_DATA_W, 32, host write beat width; BM_COL_W must be a multiple of it
- BEATS (local), BM_COL_W/HOST_DATA_W (8), beats per column
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- host_bm_clr  in  1  synchronous clear: invalidate all columns, drop partial column
- host_bm_wr_en  in  1  write beat valid
- host_bm_wr_addr  in  BM_MEM_ADDR_W  target column; sampled on beat 0 only
- host_bm_wr_data  in  HOST_DATA_W  beat data
- bm_mem_wr_busy  out  1  partial column in progress (beat counter != 0)
- bm_mem_col_valid  out  M_MAX  per-column valid flags
- bm_cntl_bm_mem_rd_rq  in  1  column read request
- bm_cntl_bm_mem_rd_addr  in  BM_MEM_ADDR_W  column to read
- bm_mem_bm_cntl_rd_data  out  BM_COL_W  column data
- bm_mem_bm_cntl_rd_data_val  out  1  one-cycle pulse, read data valid
- bm_mem_rd_err  out  1  one-cycle pulse, read hit an invalid or out-of-range column

## Operation
- Storage: M_MAX x BM_COL_W register array, plus a col_valid[M_MAX] flag per column. Array contents are not reset; col_valid is.
- Write assembly:
  - beat_cnt counts 0..BEATS-1.
  - Beat n lands at bits [n*HOST_DATA_W +: HOST_DATA_W] of an assembly register.
  - On beat 0, wr_addr is latched into col_addr_q.
  - The final beat (beat_cnt==BEATS-1 with wr_en) commits the column to array[col_addr_q]. The last beat's data is used directly, not via the assembly register. The same cycle sets col_valid[col_addr_q], and beat_cnt wraps to 0.
  - Gaps between beats are allowed; beat_cnt holds while wr_en is low.
  - Rewriting a valid column overwrites it. col_valid stays 1 throughout.
  - If col_addr_q >= M_MAX, the commit is discarded and no flag changes.
- Clear: host_bm_clr zeroes col_valid and beat_cnt. When it coincides with wr_en, clear wins and the beat is dropped.
- Read: rd_rq samples rd_addr.
  - Valid, in-range column: next cycle rd_data = array[addr], rd_data_val=1, rd_err=0.
  - Invalid or out-of-range column: next cycle rd_data = 0, rd_data_val=1, rd_err=1.
- Without rd_rq, rd_data holds its last value and rd_data_val and rd_err are 0.

## Timing
- Reset values: rd_data=0, rd_data_val=0, rd_err=0, bm_mem_wr_busy=0, bm_mem_col_valid=0. beat_cnt=0, col_addr_q=0, assembly register=0.
- Read latency is exactly 1 cycle. Back-to-back requests every cycle are supported, with one val pulse per request. There is no backpressure.
- Read/commit collision: a read in the same cycle as a commit to the same column returns the old data and old valid status (read-before-write). The new data is visible to a request issued the cycle after the commit.
- Read in the same cycle as host_bm_clr uses the pre-clear col_valid. Requests from the next cycle onward see all columns invalid.
- bm_mem_col_valid and bm_mem_wr_busy are registered and update the cycle after the commit, beat, or clear.
- Reset asserted mid-column discards the partial column.
- Reset asserted with a read outstanding suppresses the val pulse.

## Test plan
- Reset, then read col 2 -> next cycle rd_data_val=1, rd_err=1, rd_data=0; bm_mem_col_valid=4'b0000.
- Write col 1 with 8 beats 32'h0000_0000..32'h0000_0007 (beat n = n), then read col 1 -> rd_data[32n+:32]=n, rd_err=0, col_valid=4'b0010. busy=1 after beat 0, and 0 after beat 7.
- Load cols 0..3 with distinct patterns, then issue reads every cycle to addresses 3,0,2,1 -> 4 consecutive val pulses, each carrying the matching pattern one cycle after its request.
- Col 0 holds pattern A; rewrite it with pattern B, reading col 0 in the same cycle as the final beat -> returns A; a read on the next cycle returns B.
- Write 4 beats to col 3, assert host_bm_clr, then write 8 beats to col 2 -> col_valid=4'b0100, col 3 stays invalid, col 2 data is correct.
- host_bm_clr asserted together with a wr_en beat 0 -> beat dropped, busy stays 0, col_valid stays 0.
